// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, 8N1 framing by default.
// Define UART_RX_PARITY_EN to expect one even-parity bit between D7 and the stop bit.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       uart_rx_data_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_frame_err_o,
    output logic       rx_parity_err_o,
    output logic       rx_active_o
);

    localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;
`endif

    state_t      state_q, state_d;
    logic        sync1_q, rx_s_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        parity_bad;
    logic        expired;
`ifdef UART_RX_PARITY_EN
    logic        par_q, par_d;
    logic        perr_q, perr_d;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            sync1_q <= uart_rx_data_i;
            rx_s_q  <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign expired = (cnt_q == 16'd0);

`ifdef UART_RX_PARITY_EN
    assign parity_bad = (par_q != ^shift_q);
`else
    assign parity_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = HALF_CNT;
                end
            end
            START: begin
                if (!expired) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (rx_s_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    cnt_d   = FULL_CNT;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (!expired) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = FULL_CNT;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (!expired) begin
                    cnt_d = cnt_q - 16'd1;
                end else begin
                    par_d   = rx_s_q;
                    cnt_d   = FULL_CNT;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (!expired) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (!rx_s_q) begin
                    // A low stop bit may be a break; hold off until the line recovers.
                    ferr_d  = 1'b1;
                    state_d = WAIT_IDLE;
                end else if (parity_bad) begin
`ifdef UART_RX_PARITY_EN
                    perr_d  = 1'b1;
`endif
                    state_d = IDLE;
                end else begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rx_data_o      = data_q;
    assign rx_valid_o     = valid_q;
    assign rx_frame_err_o = ferr_q;
    assign rx_active_o    = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err_o = perr_q;
`else
    assign rx_parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: frames are described as expected events (cycle, kind, data)
// derived from the framing rules and latency formula, and matched by a per-cycle monitor.
module tb_uart_rx;

    localparam int C = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int LAT    = 2 + C / 2 + 10 * C + 1;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int LAT    = 2 + C / 2 + 9 * C + 1;
`endif

    typedef struct {
        int         cyc;
        int         kind;   // 0 valid, 1 frame error, 2 parity error
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ferr, rx_perr, rx_active;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_data = 8'h00;
    ev_t        exp_q[$];
    ev_t        mon_ev;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .uart_rx_data_i (rx),
        .rx_data_o      (rx_data),
        .rx_valid_o     (rx_valid),
        .rx_frame_err_o (rx_ferr),
        .rx_parity_err_o(rx_perr),
        .rx_active_o    (rx_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_ev = exp_q.pop_front();
                check("valid", {31'd0, rx_valid}, {31'd0, mon_ev.kind == 0});
                check("frame_err", {31'd0, rx_ferr}, {31'd0, mon_ev.kind == 1});
                check("parity_err", {31'd0, rx_perr}, {31'd0, mon_ev.kind == 2});
                check("data", {24'd0, rx_data}, {24'd0, mon_ev.data});
            end else if (rx_valid || rx_ferr || rx_perr) begin
                check("spurious_strobe", {29'd0, rx_valid, rx_ferr, rx_perr}, 32'd0);
            end
        end
    end

    task automatic drive(input logic b, input int n);
        rx = b;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stop bit is driven for one bit time; the caller extends a low stop bit if needed.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
        ev_t e;
        e.cyc = cyc + LAT;
        if (!stop_b) begin
            e.kind = 1;
            e.data = model_data;
        end else if (PAR_EN && par_flip) begin
            e.kind = 2;
            e.data = model_data;
        end else begin
            e.kind = 0;
            e.data = d;
            model_data = d;
        end
        exp_q.push_back(e);
        drive(1'b0, C);
        for (int i = 0; i < 8; i++) drive(d[i], C);
        if (PAR_EN) drive((^d) ^ par_flip, C);
        drive(stop_b, C);
    endtask

    initial begin
        logic [7:0] d;
        int r;
        int gap;

        repeat (3) @(posedge clk);
        #1;
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_ferr", {31'd0, rx_ferr}, 32'd0);
        check("rst_perr", {31'd0, rx_perr}, 32'd0);
        check("rst_active", {31'd0, rx_active}, 32'd0);
        rst = 1'b0;
        drive(1'b1, 10);

        fork
            send_frame(8'h55, 1'b1, 1'b0);
            begin
                repeat (40) @(posedge clk);
                #1;
                check("frame_active", {31'd0, rx_active}, 32'd1);
            end
        join
        drive(1'b1, 4);
        check("idle_active", {31'd0, rx_active}, 32'd0);

        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        drive(1'b1, 10);

        // Two-cycle glitch: start is qualified at mid-bit and rejected.
        drive(1'b0, 2);
        drive(1'b1, 2);
        check("glitch_active_rise", {31'd0, rx_active}, 32'd1);
        drive(1'b1, 6);
        check("glitch_active_fall", {31'd0, rx_active}, 32'd0);
        check("glitch_data", {24'd0, rx_data}, {24'd0, model_data});
        drive(1'b1, 10);

        send_frame(8'h0F, 1'b0, 1'b0);
        drive(1'b0, 22);
        check("break_active", {31'd0, rx_active}, 32'd1);
        drive(1'b1, 8);
        check("break_recover", {31'd0, rx_active}, 32'd0);
        send_frame(8'h81, 1'b1, 1'b0);
        drive(1'b1, 10);

        // Reset in the middle of data bit 4.
        drive(1'b0, C);
        for (int i = 0; i < 4; i++) drive(1'b1, C);
        drive(1'b0, 3);
        rst = 1'b1;
        rx  = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_data", {24'd0, rx_data}, 32'd0);
        check("mid_rst_active", {31'd0, rx_active}, 32'd0);
        check("mid_rst_strobes", {29'd0, rx_valid, rx_ferr, rx_perr}, 32'd0);
        rst = 1'b0;
        model_data = 8'h00;
        drive(1'b1, 10);
        send_frame(8'hC3, 1'b1, 1'b0);
        drive(1'b1, 10);

        if (PAR_EN) begin
            send_frame(8'h07, 1'b1, 1'b0);
            send_frame(8'h07, 1'b1, 1'b1);
            drive(1'b1, 10);
        end

        for (int n = 0; n < 25; n++) begin
            d   = 8'($urandom);
            r   = int'($urandom_range(0, 9));
            send_frame(d, r != 0, r == 1);
            if (r == 0) begin
                drive(1'b0, int'($urandom_range(0, 20)));
                drive(1'b1, C);
            end
            gap = int'($urandom_range(0, 12));
            if (gap > 0) drive(1'b1, gap);
        end

        drive(1'b1, 100);
        check("pending_events", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART link: deserializes an 8N1 frame (optionally 8E1) from an asynchronous RX pin into a byte. Presents each byte with a single-cycle valid strobe. Sits directly downstream of the UART transmit path and consumes its serial output, whether over the board link or in loopback. Provides the receive half used by on-board echo and loopback tests.

## Interface
Parameters:
- CLKS_PER_BIT, 868: clock cycles per bit (100 MHz / 115200); legal range 4..65535.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous and active-high.
- uart_rx_data_i  in  1  asynchronous serial line; idle high.
- rx_data_o  out  8  last correctly received byte; reset 8'h00.
- rx_valid_o  out  1  one-cycle strobe, rx_data_o updated this cycle; reset 0.
- rx_frame_err_o  out  1  one-cycle strobe, stop bit sampled low; reset 0.
- rx_parity_err_o  out  1  one-cycle strobe, parity mismatch; constant 0 without UART_RX_PARITY_EN; reset 0.
- rx_active_o  out  1  high while a frame is in progress; reset 0.

## Operation
- Input passes through a 2-flop synchronizer; the synchronizer resets to 1 (idle). All logic uses the synchronized value `rx_s`.
- Bit counter: 16 bits, wide enough for CLKS_PER_BIT-1. Bit index: 3 bits.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP, WAIT_IDLE.
- IDLE:
  - When rx_s=0, go to START, load counter with CLKS_PER_BIT/2 - 1 (floor), assert rx_active_o.
- START:
  - At counter 0, sample rx_s.
  - If 1 (glitch), return to IDLE; rx_active_o drops and no strobes are issued.
  - If 0, go to DATA with counter CLKS_PER_BIT-1 and index 0.
- DATA:
  - At each counter expiry, shift rx_s into the shift register LSB-first and reload the counter.
  - After index 7, go to PARITY if compiled in, otherwise STOP.
- PARITY: at expiry, sample the parity bit, then go to STOP.
- STOP, at expiry:
  - rx_s=1 with no parity error: load rx_data_o, pulse rx_valid_o, go to IDLE.
  - rx_s=0: pulse rx_frame_err_o, leave rx_data_o unchanged, no valid strobe, go to WAIT_IDLE.
  - rx_s=1 with parity error: pulse rx_parity_err_o, leave rx_data_o unchanged, no valid strobe, go to IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a break condition from being decoded as frames.
- rx_active_o is high in every state except IDLE.
- Never more than one of rx_valid_o, rx_frame_err_o, rx_parity_err_o is high in a cycle.
- rst_i asserted in any state, including mid-frame:
  - next cycle: IDLE, all outputs at reset values, synchronizer = 1;
  - any partial frame is discarded;
  - a line still low after reset release is treated as a new start bit.

## Timing
- Pin to rx_s: 2 cycles.
- Let t0 be the cycle IDLE sees rx_s=0. Result strobe is asserted at t0 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1; add CLKS_PER_BIT with parity.
- The strobe is high for exactly 1 cycle. The FSM is back in IDLE the cycle after, so back-to-back frames with one stop bit are received without loss.
- Sampling point is mid-bit, which tolerates ±(CLKS_PER_BIT/2 - 2) cycles of cumulative drift per frame.
- No back-pressure: the consumer must capture rx_data_o on rx_valid_o. rx_data_o holds its value until the next valid byte.

## Configuration
- UART_RX_PARITY_EN defined:
  - one even-parity bit is expected between D7 and the stop bit;
  - a mismatch produces rx_parity_err_o and no valid strobe.
- Undefined:
  - 8N1 framing, and the PARITY state is not built;
  - rx_parity_err_o is tied to 0.

## Test plan
All scenarios use CLKS_PER_BIT=8 and a 10 ns clock. The bench drives bits at exactly 8 cycles.
- Frame 0x55 with 1 stop bit -> single rx_valid_o pulse, rx_data_o=8'h55 at the cycle computed in Timing, rx_active_o high for the frame.
- Back-to-back 0xA5 then 0x3C, no idle gap -> two valid pulses 80 cycles apart, data 8'hA5 then 8'h3C, no error strobes.
- Line low for 2 cycles then high -> rx_active_o rises, falls within 4 cycles of the mid-start sample; no strobes; rx_data_o unchanged.
- Frame 0x0F with stop bit 0, line held low 30 cycles -> rx_frame_err_o pulse, no valid, rx_data_o keeps its previous value, FSM stays in WAIT_IDLE until the line rises; a following frame 0x81 is received correctly.
- rst_i pulsed during bit 4 of a frame -> all outputs 0 the next cycle; a subsequent frame 0xC3 is received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity 1 -> valid with 8'h07; 0x07 with parity 0 -> rx_parity_err_o pulse, no valid.
